// File: rtl/arm_shift_pkg.sv
// Shared types and field positions for the ARM operand-2 shifter.
// shift_type_e : shifter type as encoded in shift_operand[6:5].
// shift_op_t   : decoded shift request (type, 8-bit amount, carry in, RRX).
//                The Rm value travels beside it because its width follows DATA_W.
// SHOP_*       : bit positions of fields inside the 12-bit shift_operand.
package arm_shift_pkg;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_e;

   typedef struct packed {
      shift_type_e sh_type;
      logic [7:0]  amount;
      logic        carry;
      logic        rrx;
   } shift_op_t;

   // Immediate form: imm8 rotated right by 2*rot4.
   localparam int SHOP_ROT_MSB     = 11;
   localparam int SHOP_ROT_LSB     = 8;
   localparam int SHOP_IMM8_MSB    = 7;
   // Register form.
   localparam int SHOP_AMT_MSB     = 11;
   localparam int SHOP_AMT_LSB     = 7;
   localparam int SHOP_TYPE_MSB    = 6;
   localparam int SHOP_TYPE_LSB    = 5;
   localparam int SHOP_REG_BIT     = 4;
   localparam int SHOP_RS_ZERO_BIT = 7;

endpackage

// File: rtl/val2_shift_pipe_core.sv
// barrel_shift_core: combinational ARM barrel shifter.
// Ports:
//   i_type    shift type (LSL/LSR/ASR/ROR)
//   i_amount  shift amount, 0..255
//   i_rm      value to shift
//   i_carry   current C flag, passed through when the amount is 0
//   i_rrx     rotate right by one through carry (overrides type/amount)
//   o_result  shifted value
//   o_carry   shifter carry-out
// Amount 0 always returns i_rm with i_carry; the #0 special encodings are
// rewritten by the decoder before they get here.
module barrel_shift_core
   import arm_shift_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  shift_type_e       i_type,
   input  logic [7:0]        i_amount,
   input  logic [DATA_W-1:0] i_rm,
   input  logic              i_carry,
   input  logic              i_rrx,
   output logic [DATA_W-1:0] o_result,
   output logic              o_carry
);

   localparam int RW = $clog2(DATA_W);

   // One extra bit on the side the data leaves from captures the last bit
   // shifted out, which is exactly the ARM carry. Amounts past the width
   // shift everything out, giving the n>W cases (0, c=0) and ASR saturation.
   logic [DATA_W:0]        w_lsl;
   logic [DATA_W:0]        w_lsr;
   logic signed [DATA_W:0] w_asr_src;
   logic signed [DATA_W:0] w_asr;
   logic [RW-1:0]          w_ror_amt;
   logic [DATA_W-1:0]      w_ror;

   assign w_lsl     = {1'b0, i_rm} << i_amount;
   assign w_lsr     = {i_rm, 1'b0} >> i_amount;
   assign w_asr_src = {i_rm, 1'b0};
   assign w_asr     = w_asr_src >>> i_amount;
   assign w_ror_amt = i_amount[RW-1:0];
   // When the rotate is 0 the left shift is by DATA_W and contributes nothing.
   assign w_ror     = (i_rm >> w_ror_amt) | (i_rm << (DATA_W - int'(w_ror_amt)));

   always_comb begin
      o_result = i_rm;
      o_carry  = i_carry;
      if (i_rrx) begin
         o_result = {i_carry, i_rm[DATA_W-1:1]};
         o_carry  = i_rm[0];
      end else if (i_amount != 8'd0) begin
         case (i_type)
            SH_LSL: {o_carry, o_result} = w_lsl;
            SH_LSR: {o_result, o_carry} = w_lsr;
            SH_ASR: {o_result, o_carry} = w_asr;
            SH_ROR: begin
               o_result = w_ror;
               o_carry  = w_ror[DATA_W-1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/val2_shift_pipe.sv
// val2_shift_pipe: pipelined operand-2 generator for the EXE stage.
// Decodes the shift_operand into a (type, amount, rm, carry, rrx) request,
// optionally registers it (PIPE_STAGES=2), then runs the barrel shifter into
// the output register. A valid/ready chain lets the consumer stall it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_mem                    load/store offset: zero-extended shift_operand
//   in_imm                    rotated 8-bit immediate
//   in_shift_operand[11:0]    instruction bits [11:0]
//   in_val_rm, in_val_rs      Rm value, Rs[7:0]
//   in_carry                  current C flag
//   out_valid/out_ready       result handshake
//   out_val2, out_carry       operand 2 and shifter carry-out
// DATA_W: power of two, 16..128 (LSR/ASR #0 encode the amount DATA_W in 8 bits).
module val2_shift_pipe
   import arm_shift_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PIPE_STAGES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mem,
   input  logic              in_imm,
   input  logic [11:0]       in_shift_operand,
   input  logic [DATA_W-1:0] in_val_rm,
   input  logic [7:0]        in_val_rs,
   input  logic              in_carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_val2,
   output logic              out_carry
);

   localparam logic [7:0] AMT_MASK = 8'(DATA_W - 1);
   localparam logic [7:0] AMT_FULL = 8'(DATA_W);

   shift_op_t         w_dec_op;
   logic [DATA_W-1:0] w_dec_rm;
   logic [7:0]        w_rot;
   logic [4:0]        w_imm_amt;

   // Every mode is reduced to a plain shifter request so the core stays simple:
   // mem and the invalid Rs form become "amount 0" pass-throughs, the immediate
   // becomes a ROR of the zero-extended imm8.
   always_comb begin
      w_dec_op  = '{sh_type: SH_LSL, amount: 8'd0, carry: in_carry, rrx: 1'b0};
      w_dec_rm  = in_val_rm;
      w_rot     = {3'b000, in_shift_operand[SHOP_ROT_MSB:SHOP_ROT_LSB], 1'b0} & AMT_MASK;
      w_imm_amt = in_shift_operand[SHOP_AMT_MSB:SHOP_AMT_LSB];
      if (in_mem) begin
         w_dec_rm = {{(DATA_W-12){1'b0}}, in_shift_operand};
      end else if (in_imm) begin
         // rot==0 lands on amount 0, which keeps the incoming carry.
         w_dec_rm         = {{(DATA_W-8){1'b0}}, in_shift_operand[SHOP_IMM8_MSB:0]};
         w_dec_op.sh_type = SH_ROR;
         w_dec_op.amount  = w_rot;
      end else begin
         w_dec_op.sh_type = shift_type_e'(in_shift_operand[SHOP_TYPE_MSB:SHOP_TYPE_LSB]);
         if (in_shift_operand[SHOP_REG_BIT]) begin
            // Bit 7 set is not a register shift; force a zero result, carry kept.
            if (in_shift_operand[SHOP_RS_ZERO_BIT])
               w_dec_rm = '0;
            else
               w_dec_op.amount = in_val_rs;
         end else if (w_imm_amt != 5'd0) begin
            w_dec_op.amount = {3'b000, w_imm_amt};
         end else begin
            case (w_dec_op.sh_type)
               SH_LSR, SH_ASR: w_dec_op.amount = AMT_FULL;
               SH_ROR:         w_dec_op.rrx    = 1'b1;
               default:        ;
            endcase
         end
      end
   end

   shift_op_t         w_core_op;
   logic [DATA_W-1:0] w_core_rm;
   logic              w_core_valid;
   logic [DATA_W-1:0] w_core_result;
   logic              w_core_carry;
   logic              w_last_ready;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_val2;
   logic              r_out_carry;

   assign w_last_ready = !r_out_valid || out_ready;

   generate
      if (PIPE_STAGES == 1) begin : g_one_stage
         assign w_core_op    = w_dec_op;
         assign w_core_rm    = w_dec_rm;
         assign w_core_valid = in_valid;
         assign in_ready     = w_last_ready;
      end else begin : g_two_stage
         shift_op_t         r_s1_op;
         logic [DATA_W-1:0] r_s1_rm;
         logic              r_s1_valid;

         assign in_ready = !r_s1_valid || w_last_ready;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_s1_valid <= 1'b0;
               r_s1_op    <= '0;
               r_s1_rm    <= '0;
            end else if (in_ready) begin
               r_s1_valid <= in_valid;
               if (in_valid) begin
                  r_s1_op <= w_dec_op;
                  r_s1_rm <= w_dec_rm;
               end
            end
         end

         assign w_core_op    = r_s1_op;
         assign w_core_rm    = r_s1_rm;
         assign w_core_valid = r_s1_valid;
      end
   endgenerate

   barrel_shift_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .i_type   (w_core_op.sh_type),
      .i_amount (w_core_op.amount),
      .i_rm     (w_core_rm),
      .i_carry  (w_core_op.carry),
      .i_rrx    (w_core_op.rrx),
      .o_result (w_core_result),
      .o_carry  (w_core_carry)
   );

   // Data only loads with a new result, so a stalled output holds steady.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_val2  <= '0;
         r_out_carry <= 1'b0;
      end else if (w_last_ready) begin
         r_out_valid <= w_core_valid;
         if (w_core_valid) begin
            r_out_val2  <= w_core_result;
            r_out_carry <= w_core_carry;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_val2  = r_out_val2;
   assign out_carry = r_out_carry;

endmodule

// File: tb/tb_val2_shift_pipe.sv
module tb_val2_shift_pipe;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_mem = 1'b0;
   logic          in_imm = 1'b0;
   logic [11:0]   in_so = '0;
   logic [W-1:0]  in_rm = '0;
   logic [7:0]    in_rs = '0;
   logic          in_carry = 1'b0;
   logic          out_ready = 1'b1;
   int            sel = 0;
   int            depth = 1;

   // Both pipeline depths are instantiated; only the selected one sees requests.
   logic          v1, v2, rdy1, rdy2, ov1, ov2, oc1, oc2;
   logic [W-1:0]  o1, o2;
   logic          w_rdy, w_ov, w_oc;
   logic [W-1:0]  w_o;

   assign v1    = in_valid && (sel == 0);
   assign v2    = in_valid && (sel == 1);
   assign w_rdy = (sel == 0) ? rdy1 : rdy2;
   assign w_ov  = (sel == 0) ? ov1  : ov2;
   assign w_oc  = (sel == 0) ? oc1  : oc2;
   assign w_o   = (sel == 0) ? o1   : o2;

   val2_shift_pipe #(.DATA_W(W), .PIPE_STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
      .in_mem(in_mem), .in_imm(in_imm), .in_shift_operand(in_so),
      .in_val_rm(in_rm), .in_val_rs(in_rs), .in_carry(in_carry),
      .out_valid(ov1), .out_ready(out_ready), .out_val2(o1), .out_carry(oc1));

   val2_shift_pipe #(.DATA_W(W), .PIPE_STAGES(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
      .in_mem(in_mem), .in_imm(in_imm), .in_shift_operand(in_so),
      .in_val_rm(in_rm), .in_val_rs(in_rs), .in_carry(in_carry),
      .out_valid(ov2), .out_ready(out_ready), .out_val2(o2), .out_carry(oc2));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s pipe=%0d got=%0h exp=%0h", tag, depth, got, exp);
      end
   endtask

   // ---------------- reference model ({carry, val2}) ----------------
   function automatic logic bit_of(input logic [W-1:0] v, input int i);
      logic [W-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int r);
      if (r == 0) return v;
      return (v >> r) | (v << (W - r));
   endfunction

   function automatic logic [W:0] ref_val2(input logic mem, input logic imm,
                                           input logic [11:0] so, input logic [W-1:0] rm,
                                           input logic [7:0] rs, input logic cin);
      int n, typ, rot;
      logic [W-1:0] v;
      if (mem) return {cin, 20'd0, so};
      if (imm) begin
         rot = (2 * int'(so[11:8])) % W;
         v   = rotr({24'd0, so[7:0]}, rot);
         return {(rot == 0) ? cin : v[W-1], v};
      end
      typ = int'(so[6:5]);
      if (so[4]) begin
         if (so[7]) return {cin, 32'd0};
         n = int'(rs);
         if (n == 0) return {cin, rm};
      end else begin
         n = int'(so[11:7]);
         if (n == 0) begin
            if (typ == 0) return {cin, rm};
            if (typ == 3) return {rm[0], cin, rm[W-1:1]};
            n = W;
         end
      end
      case (typ)
         0: begin
            if (n < W)  return {bit_of(rm, W - n), rm << n};
            if (n == W) return {rm[0], 32'd0};
            return {1'b0, 32'd0};
         end
         1: begin
            if (n < W)  return {bit_of(rm, n - 1), rm >> n};
            if (n == W) return {rm[W-1], 32'd0};
            return {1'b0, 32'd0};
         end
         2: begin
            if (n < W) return {bit_of(rm, n - 1), $unsigned($signed(rm) >>> n)};
            return {rm[W-1], {W{rm[W-1]}}};
         end
         default: begin
            rot = n % W;
            if (rot == 0) return {rm[W-1], rm};
            return {bit_of(rm, rot - 1), rotr(rm, rot)};
         end
      endcase
   endfunction

   // ---------------- scoreboard / monitor (negedge) ----------------
   logic [W:0] q[$];
   logic       use_fixed = 1'b0;
   logic [W:0] cur_exp = '0;
   logic       prev_stall = 1'b0;
   logic [W:0] prev_out = '0;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("hold", 64'({w_ov, w_oc, w_o}), 64'({1'b1, prev_out}));
         chk("in_ready", 64'(w_rdy), 64'((q.size() < depth) || out_ready));
         if (w_ov && out_ready) begin
            if (q.size() == 0)
               chk("extra_out", 64'(q.size()), 64'd1);
            else
               chk("val2", 64'({w_oc, w_o}), 64'(q.pop_front()));
         end
         if (in_valid && w_rdy)
            q.push_back(use_fixed ? cur_exp : ref_val2(in_mem, in_imm, in_so, in_rm, in_rs, in_carry));
         prev_stall = w_ov && !out_ready;
         prev_out   = {w_oc, w_o};
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic mem, input logic imm, input logic [11:0] so,
                       input logic [W-1:0] rm, input logic [7:0] rs, input logic cin,
                       input logic fixed, input logic [W:0] exp);
      int t;
      in_mem = mem; in_imm = imm; in_so = so; in_rm = rm; in_rs = rs; in_carry = cin;
      use_fixed = fixed; cur_exp = exp;
      in_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!w_rdy && t < 100);
      if (!w_rdy) chk("accept_timeout", 64'(w_rdy), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [7:0] rs;
      int m;
      logic [W-1:0] rm;
      m  = $urandom_range(0, 7);
      rm = ($urandom_range(0, 5) == 0) ? 32'h8000_0001 : W'($urandom);
      case ($urandom_range(0, 5))
         0: rs = 8'd0;
         1: rs = 8'd31;
         2: rs = 8'd32;
         3: rs = 8'd33;
         default: rs = 8'($urandom);
      endcase
      send(m == 0, m inside {[1:2]}, 12'($urandom), rm, rs, 1'($urandom), 1'b0, '0);
   endtask

   task automatic dvec(input logic mem, input logic imm, input logic [11:0] so,
                       input logic [W-1:0] rm, input logic [7:0] rs, input logic cin,
                       input logic [W:0] exp);
      int k;
      send(mem, imm, so, rm, rs, cin, 1'b1, exp);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!w_ov && k < 10);
      chk("latency", 64'(k), 64'(depth));
      tick();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic do_reset(input int s);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      sel = s; depth = s + 1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(w_ov), 64'd0);
      chk("rst_out_val2", 64'(w_o), 64'd0);
      chk("rst_out_carry", 64'(w_oc), 64'd0);
      chk("rst_in_ready", 64'(w_rdy), 64'd1);
      tick();
   endtask

   logic done;

   initial begin
      for (int s = 0; s < 2; s++) begin
         do_reset(s);

         // directed vectors with hand-derived results
         dvec(0, 1, 12'h4FF, 32'h1234_5678, 8'd0,  0, {1'b1, 32'hFF00_0000});
         dvec(0, 1, 12'h0AB, 32'h1234_5678, 8'd0,  0, {1'b0, 32'h0000_00AB});
         dvec(0, 1, 12'h000, 32'h1234_5678, 8'd0,  1, {1'b1, 32'h0000_0000});
         dvec(0, 0, 12'h020, 32'h8000_0001, 8'd0,  0, {1'b1, 32'h0000_0000});
         dvec(0, 0, 12'h040, 32'h8000_0001, 8'd0,  0, {1'b1, 32'hFFFF_FFFF});
         dvec(0, 0, 12'h060, 32'h8000_0001, 8'd0,  1, {1'b1, 32'hC000_0000});
         dvec(0, 0, 12'h200, 32'h8000_0001, 8'd0,  1, {1'b0, 32'h0000_0010});
         dvec(0, 0, 12'h010, 32'h0000_000F, 8'd32, 0, {1'b1, 32'h0000_0000});
         dvec(0, 0, 12'h010, 32'h0000_000F, 8'd33, 1, {1'b0, 32'h0000_0000});
         dvec(0, 0, 12'h010, 32'h0000_000F, 8'd0,  1, {1'b1, 32'h0000_000F});
         dvec(0, 0, 12'h010, 32'h0000_000F, 8'd0,  0, {1'b0, 32'h0000_000F});
         dvec(0, 0, 12'h070, 32'h0000_000F, 8'd36, 0, {1'b1, 32'hF000_0000});
         dvec(1, 1, 12'hFFF, 32'hDEAD_BEEF, 8'd7,  1, {1'b1, 32'h0000_0FFF});
         dvec(0, 0, 12'h090, 32'h0000_000F, 8'd5,  1, {1'b1, 32'h0000_0000});
         drain();

         // random traffic with random backpressure
         done = 1'b0;
         fork
            begin
               for (int i = 0; i < 80; i++) send_rand();
               done = 1'b1;
            end
            begin
               while (!done) begin
                  out_ready = ($urandom_range(0, 3) != 0);
                  tick();
               end
               out_ready = 1'b1;
            end
         join
         drain();

         // six back-to-back requests, consumer stalls for cycles 3-5
         fork
            begin
               for (int i = 0; i < 6; i++) send_rand();
            end
            begin
               for (int c = 1; c <= 12; c++) begin
                  out_ready = !(c >= 3 && c <= 5);
                  tick();
               end
            end
         join
         out_ready = 1'b1;
         drain();

         // reset with two requests in flight
         send_rand();
         send_rand();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         @(negedge clk);
         chk("midrst_out_valid", 64'(w_ov), 64'd0);
         chk("midrst_out_val2", 64'(w_o), 64'd0);
         tick();
         dvec(0, 0, 12'h200, 32'h8000_0001, 8'd0, 1, {1'b0, 32'h0000_0010});
         drain();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
